// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer for the 5-stage F/D/E/M/W integer pipeline.
// Resolves stall/flush controls from data-bus waits, multi-cycle execute,
// EX-stage redirects and load-use hazards. It also owns the fetch-redirect
// drain FSM and two performance counters.
module pipe_hazard_ctrl #(
    parameter int unsigned PC_W  = 64,
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_ibus_busy,
    input  logic             i_dbus_busy,
    input  logic             i_ex_busy,
    input  logic             i_ex_valid,
    input  logic             i_ex_is_load,
    input  logic [REG_W-1:0] i_ex_dst,
    input  logic             i_id_valid,
    input  logic [REG_W-1:0] i_id_rs1,
    input  logic [REG_W-1:0] i_id_rs2,
    input  logic             i_id_use_rs1,
    input  logic             i_id_use_rs2,
    input  logic             i_redirect_req,
    input  logic [PC_W-1:0]  i_redirect_pc,
    output logic             o_stall_f,
    output logic             o_stall_d,
    output logic             o_stall_e,
    output logic             o_stall_m,
    output logic             o_flush_d,
    output logic             o_flush_e,
    output logic             o_flush_m,
    output logic             o_pc_load,
    output logic [PC_W-1:0]  o_pc_target,
    output logic             o_drop_fetch,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    typedef enum logic [0:0] {StIdle, StDrain} state_e;

    state_e          r_state;
    state_e          w_state_nxt;
    logic [PC_W-1:0] r_target;
    logic [PC_W-1:0] w_target_nxt;

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_p1_dbus;
    logic w_p2_exbusy;
    logic w_redir_acc;
    logic w_load_use_raw;
    logic w_load_use;
    logic w_in_drain;

    // Priority decode of the four hazard sources.
    always_comb begin
        w_p1_dbus      = i_dbus_busy;
        w_p2_exbusy    = !i_dbus_busy && i_ex_busy;
        w_redir_acc    = !i_dbus_busy && !i_ex_busy && i_redirect_req && i_ex_valid;
        w_load_use_raw = i_ex_valid && i_ex_is_load && (i_ex_dst != '0) && i_id_valid &&
                         ((i_id_use_rs1 && (i_id_rs1 == i_ex_dst)) ||
                          (i_id_use_rs2 && (i_id_rs2 == i_ex_dst)));
        // A redirect kills the D instruction anyway, so load-use is moot.
        w_load_use     = w_load_use_raw && !i_dbus_busy && !i_ex_busy && !w_redir_acc;
        w_in_drain     = (r_state == StDrain);
    end

    // Per-stage stall and bubble controls.
    always_comb begin
        o_stall_f = w_p1_dbus || w_p2_exbusy || w_load_use;
        o_stall_d = w_p1_dbus || w_p2_exbusy || w_load_use;
        o_stall_e = w_p1_dbus || w_p2_exbusy;
        o_stall_m = w_p1_dbus;
        // While draining, keep D empty; a frozen pipeline takes no flushes.
        o_flush_d = !w_p1_dbus && (w_redir_acc || w_in_drain);
        o_flush_e = w_redir_acc || w_load_use;
        o_flush_m = w_p2_exbusy;
    end

    // Fetch-redirect FSM: next state, saved target and PC load outputs.
    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        o_pc_load    = 1'b0;
        o_pc_target  = '0;
        o_drop_fetch = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_redir_acc) begin
                    if (i_ibus_busy) begin
                        w_state_nxt  = StDrain;
                        w_target_nxt = i_redirect_pc;
                    end else begin
                        o_pc_load   = 1'b1;
                        o_pc_target = i_redirect_pc;
                    end
                end
            end
            StDrain: begin
                // The wrong-path response returning now is always discarded.
                o_drop_fetch = !i_ibus_busy;
                if (w_redir_acc) begin
                    // A newer redirect wins, even in the exit cycle.
                    w_target_nxt = i_redirect_pc;
                end else if (!i_ibus_busy) begin
                    o_pc_load   = 1'b1;
                    o_pc_target = r_target;
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // FSM state and saved redirect target.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= StIdle;
            r_target <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_target <= w_target_nxt;
        end
    end

    // Performance counters, wrapping naturally.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, o_stall_f};
            r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, w_redir_acc};
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// randomized traffic, all checked against a behavioural model of the rules.
module tb_pipe_hazard_ctrl;

    localparam int unsigned PC_W  = 64;
    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 32;

    logic             i_clk = 1'b0;
    logic             i_reset;
    logic             i_ibus_busy, i_dbus_busy, i_ex_busy, i_ex_valid, i_ex_is_load;
    logic [REG_W-1:0] i_ex_dst, i_id_rs1, i_id_rs2;
    logic             i_id_valid, i_id_use_rs1, i_id_use_rs2, i_redirect_req;
    logic [PC_W-1:0]  i_redirect_pc;
    logic             o_stall_f, o_stall_d, o_stall_e, o_stall_m;
    logic             o_flush_d, o_flush_e, o_flush_m, o_pc_load, o_drop_fetch;
    logic [PC_W-1:0]  o_pc_target;
    logic [CNT_W-1:0] o_stall_cnt, o_flush_cnt;

    int checks   = 0;
    int failures = 0;

    // Model state: is a redirect waiting for the fetch to drain, and where to.
    bit               m_pending;
    logic [PC_W-1:0]  m_target;
    logic [CNT_W-1:0] m_stall_cnt, m_flush_cnt;

    pipe_hazard_ctrl #(.PC_W(PC_W), .REG_W(REG_W), .CNT_W(CNT_W)) u_dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_ibus_busy    (i_ibus_busy),
        .i_dbus_busy    (i_dbus_busy),
        .i_ex_busy      (i_ex_busy),
        .i_ex_valid     (i_ex_valid),
        .i_ex_is_load   (i_ex_is_load),
        .i_ex_dst       (i_ex_dst),
        .i_id_valid     (i_id_valid),
        .i_id_rs1       (i_id_rs1),
        .i_id_rs2       (i_id_rs2),
        .i_id_use_rs1   (i_id_use_rs1),
        .i_id_use_rs2   (i_id_use_rs2),
        .i_redirect_req (i_redirect_req),
        .i_redirect_pc  (i_redirect_pc),
        .o_stall_f      (o_stall_f),
        .o_stall_d      (o_stall_d),
        .o_stall_e      (o_stall_e),
        .o_stall_m      (o_stall_m),
        .o_flush_d      (o_flush_d),
        .o_flush_e      (o_flush_e),
        .o_flush_m      (o_flush_m),
        .o_pc_load      (o_pc_load),
        .o_pc_target    (o_pc_target),
        .o_drop_fetch   (o_drop_fetch),
        .o_stall_cnt    (o_stall_cnt),
        .o_flush_cnt    (o_flush_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        i_ibus_busy = 0; i_dbus_busy = 0; i_ex_busy = 0; i_ex_valid = 0;
        i_ex_is_load = 0; i_ex_dst = 0; i_id_valid = 0; i_id_rs1 = 0; i_id_rs2 = 0;
        i_id_use_rs1 = 0; i_id_use_rs2 = 0; i_redirect_req = 0; i_redirect_pc = 0;
    endtask

    task automatic model_reset();
        m_pending   = 0;
        m_target    = 0;
        m_stall_cnt = 0;
        m_flush_cnt = 0;
    endtask

    // Called just after a falling edge with inputs applied: checks every output
    // against the rules, then advances the model across the next rising edge.
    task automatic check_cycle();
        bit e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fm, e_pcl, e_drop, taken, lu;
        bit               n_pending;
        logic [PC_W-1:0]  e_tgt, n_target;
        #1;
        lu = i_ex_valid && i_ex_is_load && (i_ex_dst != 0) && i_id_valid &&
             ((i_id_use_rs1 && i_id_rs1 == i_ex_dst) || (i_id_use_rs2 && i_id_rs2 == i_ex_dst));
        {e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fm, taken} = '0;
        if (i_dbus_busy) begin
            {e_sf, e_sd, e_se, e_sm} = 4'b1111;
        end else if (i_ex_busy) begin
            {e_sf, e_sd, e_se, e_fm} = 4'b1111;
            e_fd = m_pending;
        end else if (i_redirect_req && i_ex_valid) begin
            taken = 1; e_fd = 1; e_fe = 1;
        end else if (lu) begin
            e_sf = 1; e_sd = 1; e_fe = 1;
            e_fd = m_pending;
        end else begin
            e_fd = m_pending;
        end
        e_pcl = 0; e_tgt = 0; e_drop = 0;
        n_pending = m_pending; n_target = m_target;
        if (!m_pending) begin
            if (taken && !i_ibus_busy) begin
                e_pcl = 1; e_tgt = i_redirect_pc;
            end else if (taken) begin
                n_pending = 1; n_target = i_redirect_pc;
            end
        end else begin
            e_drop = !i_ibus_busy;
            if (taken) n_target = i_redirect_pc;
            else if (!i_ibus_busy) begin
                e_pcl = 1; e_tgt = m_target; n_pending = 0;
            end
        end
        check_eq("stall_f", 64'(o_stall_f), 64'(e_sf));
        check_eq("stall_d", 64'(o_stall_d), 64'(e_sd));
        check_eq("stall_e", 64'(o_stall_e), 64'(e_se));
        check_eq("stall_m", 64'(o_stall_m), 64'(e_sm));
        check_eq("flush_d", 64'(o_flush_d), 64'(e_fd));
        check_eq("flush_e", 64'(o_flush_e), 64'(e_fe));
        check_eq("flush_m", 64'(o_flush_m), 64'(e_fm));
        check_eq("pc_load", 64'(o_pc_load), 64'(e_pcl));
        check_eq("pc_target", o_pc_target, e_tgt);
        check_eq("drop_fetch", 64'(o_drop_fetch), 64'(e_drop));
        check_eq("stall_cnt", 64'(o_stall_cnt), 64'(m_stall_cnt));
        check_eq("flush_cnt", 64'(o_flush_cnt), 64'(m_flush_cnt));
        @(posedge i_clk);
        m_pending = n_pending;
        m_target  = n_target;
        m_stall_cnt += CNT_W'(e_sf);
        m_flush_cnt += CNT_W'(taken);
        @(negedge i_clk);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ctrl"}, 64'({o_stall_f, o_stall_d, o_stall_e, o_stall_m, o_flush_d,
                 o_flush_e, o_flush_m, o_pc_load, o_drop_fetch}), 64'd0);
        check_eq({tag, "_tgt"}, o_pc_target, 64'd0);
        check_eq({tag, "_scnt"}, 64'(o_stall_cnt), 64'd0);
        check_eq({tag, "_fcnt"}, 64'(o_flush_cnt), 64'd0);
    endtask

    initial begin
        clear_inputs();
        model_reset();
        i_reset = 1;
        #2;
        check_all_zero("reset");
        @(negedge i_clk);
        i_reset = 0;
        check_cycle();

        // Load-use on rs1, then the same with a non-writing load.
        i_ex_valid = 1; i_ex_is_load = 1; i_ex_dst = 5;
        i_id_valid = 1; i_id_use_rs1 = 1; i_id_rs1 = 5;
        #1;
        check_eq("lu_stall_f", 64'(o_stall_f), 64'd1);
        check_eq("lu_stall_e", 64'(o_stall_e), 64'd0);
        check_eq("lu_flush_e", 64'(o_flush_e), 64'd1);
        check_cycle();
        i_ex_dst = 0; i_id_rs1 = 0;
        check_cycle();

        // Redirect with fetch idle: loads PC in the same cycle.
        clear_inputs();
        i_redirect_req = 1; i_ex_valid = 1; i_redirect_pc = 64'h8000_0100;
        #1;
        check_eq("redir_pc_load", 64'(o_pc_load), 64'd1);
        check_eq("redir_pc_target", o_pc_target, 64'h8000_0100);
        check_cycle();
        check_eq("redir_flush_cnt", 64'(o_flush_cnt), 64'd1);

        // Redirect while a fetch is outstanding: drain for 3 cycles.
        i_redirect_pc = 64'h8000_0200; i_ibus_busy = 1;
        check_cycle();
        clear_inputs();
        i_ibus_busy = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("drain_flush_d", 64'(o_flush_d), 64'd1);
            check_cycle();
        end
        i_ibus_busy = 0;
        #1;
        check_eq("drain_drop", 64'(o_drop_fetch), 64'd1);
        check_eq("drain_target", o_pc_target, 64'h8000_0200);
        check_cycle();

        // dbus_busy outranks redirect and load-use; redirect taken once released.
        i_dbus_busy = 1; i_redirect_req = 1; i_ex_valid = 1; i_redirect_pc = 64'h1234;
        i_ex_is_load = 1; i_ex_dst = 3; i_id_valid = 1; i_id_use_rs2 = 1; i_id_rs2 = 3;
        #1;
        check_eq("prio_pc_load", 64'(o_pc_load), 64'd0);
        check_cycle();
        i_dbus_busy = 0;
        check_cycle();

        // Four cycles of multi-cycle execute.
        clear_inputs();
        i_ex_busy = 1;
        for (int i = 0; i < 4; i++) check_cycle();
        i_ex_busy = 0;
        check_cycle();

        // Asynchronous reset mid-drain.
        i_redirect_req = 1; i_ex_valid = 1; i_redirect_pc = 64'h8000_0300; i_ibus_busy = 1;
        check_cycle();
        clear_inputs();
        i_ibus_busy = 1;
        #1;
        i_reset = 1;
        #1;
        check_all_zero("async_rst");
        model_reset();
        #1;
        i_reset = 0;
        @(negedge i_clk);
        check_cycle();
        i_ibus_busy = 0;
        #1;
        check_eq("post_rst_pc_load", 64'(o_pc_load), 64'd0);
        check_cycle();

        // Randomized traffic with small register numbers to provoke hazards.
        for (int n = 0; n < 600; n++) begin
            i_ibus_busy    = ($urandom_range(0, 9) < 6);
            i_dbus_busy    = ($urandom_range(0, 9) < 2);
            i_ex_busy      = ($urandom_range(0, 9) < 2);
            i_ex_valid     = ($urandom_range(0, 9) < 8);
            i_ex_is_load   = $urandom_range(0, 1);
            i_ex_dst       = REG_W'($urandom_range(0, 3));
            i_id_valid     = ($urandom_range(0, 9) < 8);
            i_id_rs1       = REG_W'($urandom_range(0, 3));
            i_id_rs2       = REG_W'($urandom_range(0, 3));
            i_id_use_rs1   = $urandom_range(0, 1);
            i_id_use_rs2   = $urandom_range(0, 1);
            i_redirect_req = ($urandom_range(0, 9) < 3);
            i_redirect_pc  = {$urandom, $urandom};
            check_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
